// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V pipeline front end.
package riscv_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned ILEN = 32;

   // addi x0, x0, 0
   localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

   // One fetched instruction together with the PC it was fetched from.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

   // Force an address onto a 4-byte boundary.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Parameterised in-order synchronous FIFO with flush; head is shown from registers.
// Depth must be a power of two so the pointers wrap naturally.
module fetch_queue #(
   parameter int unsigned Width = 64,
   parameter int unsigned Depth = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic [Width-1:0]           data_i,
   input  logic                       pop_i,
   output logic [Width-1:0]           head_o,
   output logic [$clog2(Depth):0]     count_o
);

   localparam int unsigned AddrW = $clog2(Depth);
   localparam int unsigned CntW  = AddrW + 1;

   typedef logic [AddrW-1:0] ptr_t;
   typedef logic [CntW-1:0]  cnt_t;

   localparam cnt_t DepthCnt = cnt_t'(Depth);

   logic [Width-1:0] mem_q [Depth];
   ptr_t             wr_ptr_q, wr_ptr_d;
   ptr_t             rd_ptr_q, rd_ptr_d;
   cnt_t             count_q, count_d;
   logic             do_push, do_pop;

   // Pointer/count update; a pop frees the slot a same-cycle push may use when full.
   always_comb begin
      do_pop   = pop_i && (count_q != '0);
      do_push  = push_i && ((count_q != DepthCnt) || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
         count_d = count_q + cnt_t'(do_push) - cnt_t'(do_pop);
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage; cleared on reset so the head reads as zero until written.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
      end else if (do_push && !flush_i) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch front end: sequential PC generation, imem request/response
// handling, an in-order fetch queue toward decode, and redirect with stale-beat drop.
// Optional macro FETCH_PERF_EN adds saturating pop / dropped-response counters.
module riscv_fetch_unit
   import riscv_pkg::*;
#(
   parameter int unsigned     Depth   = 4,
   parameter logic [XLEN-1:0] ResetPc = '0
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   output logic            imem_req_valid_o,
   input  logic            imem_req_ready_i,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_rsp_valid_i,
   input  logic [XLEN-1:0] imem_rsp_data_i,
   input  logic            redirect_valid_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            if_valid_o,
   input  logic            if_ready_i,
   output logic [XLEN-1:0] if_pc_o,
   output logic [XLEN-1:0] if_instr_o
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]     perf_fetched_o,
   output logic [31:0]     perf_flushed_o
`endif
);

   localparam int unsigned CntW = $clog2(Depth) + 1;

   typedef logic [CntW-1:0] cnt_t;

   localparam logic [CntW:0] DepthSum = (CntW + 1)'(Depth);

   logic [XLEN-1:0] pc_q, pc_d;
   cnt_t            inflight_q, inflight_d;
   cnt_t            drop_q, drop_d;
   logic            en_q;

   cnt_t            q_count, tag_count;
   fetch_entry_t    q_head, q_wdata;
   logic [XLEN-1:0] tag_head;
   logic [CntW:0]   occupancy;
   logic            req_fire, rsp_take, rsp_drop, rsp_keep, q_push, q_pop;

   // Request only when queued plus outstanding words still fit in the queue.
   always_comb begin
      occupancy        = {1'b0, q_count} + {1'b0, inflight_q};
      imem_req_valid_o = en_q && !redirect_valid_i && (occupancy < DepthSum);
   end

   assign imem_addr_o = pc_q;
   assign req_fire    = imem_req_valid_o && imem_req_ready_i;
   // Tag FIFO occupancy tracks outstanding requests; a response with none is ignored.
   assign rsp_take    = imem_rsp_valid_i && (tag_count != '0);
   assign rsp_drop    = rsp_take && (drop_q != '0);
   assign rsp_keep    = rsp_take && (drop_q == '0);
   assign q_push      = rsp_keep && !redirect_valid_i;
   assign q_pop       = if_valid_o && if_ready_i && !redirect_valid_i;
   assign q_wdata     = '{pc: tag_head, instr: imem_rsp_data_i};

   // PC, outstanding-count and drop-count next state; redirect has priority.
   always_comb begin
      pc_d       = pc_q;
      inflight_d = inflight_q;
      drop_d     = drop_q;
      if (redirect_valid_i) begin
         pc_d       = word_align(redirect_pc_i);
         // inflight already includes beats still marked for drop, so every
         // request left outstanding after this cycle is stale.
         inflight_d = inflight_q - cnt_t'(rsp_take);
         drop_d     = inflight_d;
      end else begin
         if (req_fire) pc_d = pc_q + XLEN'(4);
         inflight_d = inflight_q + cnt_t'(req_fire) - cnt_t'(rsp_take);
         if (rsp_drop) drop_d = drop_q - cnt_t'(1);
      end
   end

   // Fetch state registers; en_q holds off requests for the first cycle out of reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q       <= ResetPc;
         inflight_q <= '0;
         drop_q     <= '0;
         en_q       <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         en_q       <= 1'b1;
      end
   end

   fetch_queue #(
      .Width ($bits(fetch_entry_t)),
      .Depth (Depth)
   ) u_fetch_q (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (redirect_valid_i),
      .push_i  (q_push),
      .data_i  (q_wdata),
      .pop_i   (q_pop),
      .head_o  (q_head),
      .count_o (q_count)
   );

   // PC tags of outstanding requests, popped by every response (kept or dropped).
   fetch_queue #(
      .Width (XLEN),
      .Depth (Depth)
   ) u_tag_q (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (1'b0),
      .push_i  (req_fire),
      .data_i  (pc_q),
      .pop_i   (rsp_take),
      .head_o  (tag_head),
      .count_o (tag_count)
   );

   assign if_valid_o = (q_count != '0);
   assign if_pc_o    = q_head.pc;
   assign if_instr_o = q_head.instr;

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched_q, perf_flushed_q;

   // Saturating counters of words delivered to decode and stale beats discarded.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_fetched_q <= '0;
         perf_flushed_q <= '0;
      end else begin
         if (q_pop && (perf_fetched_q != '1))    perf_fetched_q <= perf_fetched_q + 32'd1;
         if (rsp_drop && (perf_flushed_q != '1)) perf_flushed_q <= perf_flushed_q + 32'd1;
      end
   end

   assign perf_fetched_o = perf_fetched_q;
   assign perf_flushed_o = perf_flushed_q;
`endif

endmodule
